// File: rtl/freq_meter.sv
// Gated frequency meter: counts sig_in rising edges per GATE_CYCLES-clock window, publishes BCD.
// Latency: 3-flop input path, result lands on the window-closing edge with a valid pulse; no backpressure.
module freq_meter #(
  parameter int GATE_CYCLES = 100000,
  parameter int DIGITS      = 4
) (
  input  logic                CP,
  input  logic                CLR_n,
  input  logic                en,
  input  logic                sig_in,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow,
  output logic                valid,
  output logic                gate
);
  localparam int            GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state_q, state_d;

  logic                s1, s2, s3, edge_pulse;
  logic [GW-1:0]       gate_cnt;
  logic [4*DIGITS-1:0] cnt, cnt_inc, cnt_sum;
  logic                sat, sat_hit, all_nines, carry;
  logic                run, close;

  always_ff @(posedge CP or posedge CLR_n) begin
    if (CLR_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

  // Ripple the decade carry; a carry out of the top digit means the count is all 9s.
  always_comb begin
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (cnt[4*k +: 4] == 4'd9) begin
          cnt_inc[4*k +: 4] = 4'd0;
        end else begin
          cnt_inc[4*k +: 4] = cnt[4*k +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    all_nines = carry;
    sat_hit   = edge_pulse & all_nines;
    cnt_sum   = (edge_pulse && !all_nines) ? cnt_inc : cnt;
  end

  always_ff @(posedge CP or posedge CLR_n) begin
    if (CLR_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    close   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          close = (gate_cnt == GATE_LAST);
          run   = ~close;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters clear on idle, abort and close alike; only a close publishes.
  always_ff @(posedge CP or posedge CLR_n) begin
    if (CLR_n) begin
      gate_cnt <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      gate     <= 1'b0;
    end else begin
      valid <= close;
      gate  <= (state_d == MEASURE);
      if (run) begin
        gate_cnt <= gate_cnt + 1'b1;
        cnt      <= cnt_sum;
        sat      <= sat | sat_hit;
      end else begin
        gate_cnt <= '0;
        cnt      <= '0;
        sat      <= 1'b0;
      end
      if (close) begin
        bcd      <= cnt_sum;
        overflow <= sat | sat_hit;
      end
    end
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency meter, the measuring counterpart of the divider. It counts rising edges of an asynchronous input signal over a fixed gate window of GATE_CYCLES clocks of CP, one second at the nominal 100 kHz CP. Each completed window's count is published as packed BCD digits for the seven-segment display path. The block runs back-to-back windows while enabled and reports an overflow flag when the count exceeds the display range.

## Interface
- GATE_CYCLES, default 100000: CP cycles per gate window (1 s at 100 kHz). Must be ≥ 2.
- DIGITS, default 4: number of BCD digits. Full scale is 10^DIGITS − 1.
- CP  in  1  system clock. All logic is rising-edge.
- CLR_n  in  1  reset CLR_n, asynchronous, active-high.
- en  in  1  measurement enable, synchronous level.
- sig_in  in  1  signal under test, asynchronous to CP.
- bcd  out  4*DIGITS  last published count. Digit 0 (units) is in bits [3:0].
- overflow  out  1  the published count saturated.
- valid  out  1  one-cycle pulse when bcd/overflow update.
- gate  out  1  high while a window is open (state MEASURE).

## Operation
- **Input path.**
  - sig_in passes through a 2-flop synchronizer (s1, s2) and then a delay flop (s3).
  - edge = s2 & ~s3.
  - The input path runs in every state.
- **State machine, two states.**
  - IDLE:
    - gate_cnt and edge counter are held at 0.
    - en=1 moves to MEASURE on the next edge.
  - MEASURE:
    - gate_cnt increments each cycle from 0 to GATE_CYCLES−1.
    - The edge counter adds edge each cycle.
    - en=0 returns to IDLE. The partial window is discarded: no valid, bcd/overflow unchanged, counters cleared.
- **Window close.**
  - A window closes in the MEASURE cycle where gate_cnt==GATE_CYCLES−1 and en=1.
  - On that edge, bcd <= edge counter + edge of that cycle, saturating. overflow <= saturation flag for the window, including this final edge.
  - On the same edge, valid <= 1, gate_cnt <= 0, edge counter <= 0, and the saturation flag is cleared.
  - The state stays MEASURE, so the next window starts with no gap.
  - Every CP cycle belongs to exactly one window, and each edge is counted exactly once.
- **Edge counter.**
  - DIGITS cascaded decade counters. Digit k increments when edge=1 and digits 0..k−1 are all 9; a digit at 9 wraps to 0.
  - Saturation: when all digits are 9 and edge=1, the count holds at all-9s and the sticky per-window saturation flag is set.
- **Gate counter width.** $clog2(GATE_CYCLES) bits, compared for equality only.
- **en timing.** en changing mid-window has effect only at the state transition. en=0 in the closing cycle counts as an abort, not a close.

## Timing
- **Reset values** (CLR_n=1, asynchronous):
  - state IDLE; s1/s2/s3 = 0.
  - gate_cnt and edge counter = 0; saturation flag = 0.
  - bcd = 0, overflow = 0, valid = 0, gate = 0.
- **Reset mid-window.** All of the above apply immediately. After release, if en=1, MEASURE is entered on the first CP edge and a full fresh window starts.
- **Input latency.** A sig_in rise that meets setup before CP edge n makes edge=1 during the cycle after edge n+1. It is counted on edge n+2.
- **First window.**
  - en is sampled high in IDLE at edge t0, so the first MEASURE cycle follows t0.
  - valid pulses during the cycle after edge t0+GATE_CYCLES.
  - bcd/overflow change on that same edge, coincident with valid.
- **Steady state.** valid pulses exactly every GATE_CYCLES cycles while en stays 1.
- **gate.** Registered, equal to (state==MEASURE). It stays high across window boundaries.
- **Input rate limit.** sig_in must have high and low times each ≥ 2 CP periods. Faster input undercounts and is not flagged.

## Test plan
- **Reset.**
  - Stimulus: assert CLR_n with en=1 and sig_in toggling.
  - Required: bcd=0, overflow=0, valid=0, gate=0 while asserted, and no valid pulse.
- **Basic count and BCD carry.**
  - Stimulus: GATE_CYCLES=100, DIGITS=4, sig_in period 4 CP (50% duty), en=1 from reset release.
  - Required: valid at cycle 101, then 201, and so on; bcd=16'h0025, overflow=0.
  - Repeat with period 5. Required: bcd=16'h0020.
- **Saturation.**
  - Stimulus: DIGITS=1, GATE_CYCLES=100, period 4.
  - Required: bcd=4'h9 and overflow=1 on every valid.
  - Then switch to period 20 at a window boundary. Required: next valid gives bcd=4'h5, overflow=0.
- **Abort.**
  - Stimulus: after one published count of 0025, drop en at gate_cnt=50, hold it low 30 cycles, then raise it.
  - Required: no valid during the abort; bcd stays 0025; the next valid comes 100 cycles after re-entry to MEASURE, with 0025.
- **Boundary edge.**
  - Stimulus: place a single sig_in pulse so edge=1 exactly in the closing cycle (gate_cnt=99).
  - Required: that window reports 0001 and the following window reports 0000.
- **Reset mid-window.**
  - Stimulus: pulse CLR_n at gate_cnt=60 with en=1 and period 4.
  - Required: outputs return to 0 immediately; the first valid after release comes GATE_CYCLES+1 cycles after release, with bcd=0025.
